// File: rtl/mdio_cfg_if.sv
// MDIO master request bundle.
// master: phy_add_o/reg_add/wr_data/wren/rden out; busy/rd_data/rd_valid in.
interface mdio_cfg_if;
    logic [4:0]  phy_add_o;
    logic [4:0]  reg_add;
    logic [15:0] wr_data;
    logic        wren;
    logic        rden;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_valid;

    modport master (
        output phy_add_o, reg_add, wr_data, wren, rden,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  phy_add_o, reg_add, wr_data, wren, rden,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/mdio_cfg_sequencer.sv
// Boot-time PHY configuration: per PHY soft reset, poll BMCR[15], write BMCR.
// Ports: clk, rst_n, start in; mdio (master modport); done/error/err_phy out.
module mdio_cfg_sequencer #(
    parameter int          NUM_PHY  = 2,
    parameter logic [4:0]  PHY_BASE = 5'h1,
    parameter int          PWR_WAIT = 1000,
    parameter int          POLL_MAX = 16,
    parameter int          BUSY_TO  = 4096,
    parameter logic [15:0] BMCR_CFG = 16'h3100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    mdio_cfg_if.master mdio,
    output logic       done,
    output logic       error,
    output logic [2:0] err_phy
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PWAIT    = 4'd1;
    localparam logic [3:0] S_RST_WR   = 4'd2;
    localparam logic [3:0] S_RST_ACK  = 4'd3;
    localparam logic [3:0] S_POLL_RD  = 4'd4;
    localparam logic [3:0] S_POLL_ACK = 4'd5;
    localparam logic [3:0] S_CFG_WR   = 4'd6;
    localparam logic [3:0] S_CFG_ACK  = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;
    localparam logic [3:0] S_ERR      = 4'd9;

    localparam int          PCW      = $clog2(POLL_MAX + 1);
    localparam logic [31:0] PW_LAST  = 32'(PWR_WAIT - 1);
    localparam logic [31:0] TO_LAST  = 32'(BUSY_TO - 1);
    localparam logic [2:0]  IDX_LAST = 3'(NUM_PHY - 1);

    logic [3:0]     state;
    logic [31:0]    cnt;
    logic [2:0]     idx;
    logic [PCW-1:0] polls;
    logic           seen_busy;
    logic           bit15;

    logic       ack_fall;
    logic       ack_to;
    logic       poll_hi;
    logic [4:0] phy_cur;

    // A transaction ends when busy falls after having been seen high.
    assign ack_fall = seen_busy & ~mdio.busy;
    assign ack_to   = (cnt == TO_LAST);
    // Read data on the deciding cycle itself still counts.
    assign poll_hi  = mdio.rd_valid ? mdio.rd_data[15] : bit15;
    assign phy_cur  = PHY_BASE + {2'b00, idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            idx            <= '0;
            polls          <= '0;
            seen_busy      <= 1'b0;
            bit15          <= 1'b0;
            mdio.phy_add_o <= '0;
            mdio.reg_add   <= '0;
            mdio.wr_data   <= '0;
            mdio.wren      <= 1'b0;
            mdio.rden      <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            err_phy        <= '0;
        end else begin
            mdio.wren <= 1'b0;
            mdio.rden <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_PWAIT;
                        cnt   <= '0;
                    end
                end
                S_PWAIT: begin
                    if (cnt == PW_LAST) begin
                        state <= S_RST_WR;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RST_WR: begin
                    if (!mdio.busy) begin
                        mdio.wren      <= 1'b1;
                        mdio.wr_data   <= 16'h8000;
                        mdio.phy_add_o <= phy_cur;
                        mdio.reg_add   <= 5'h0;
                        cnt            <= '0;
                        seen_busy      <= 1'b0;
                        polls          <= '0;
                        state          <= S_RST_ACK;
                    end
                end
                S_POLL_RD: begin
                    if (!mdio.busy) begin
                        mdio.rden      <= 1'b1;
                        mdio.phy_add_o <= phy_cur;
                        mdio.reg_add   <= 5'h0;
                        cnt            <= '0;
                        seen_busy      <= 1'b0;
                        polls          <= polls + 1'b1;
                        // No read strobe means still in reset.
                        bit15          <= 1'b1;
                        state          <= S_POLL_ACK;
                    end
                end
                S_CFG_WR: begin
                    if (!mdio.busy) begin
                        mdio.wren      <= 1'b1;
                        mdio.wr_data   <= BMCR_CFG;
                        mdio.phy_add_o <= phy_cur;
                        mdio.reg_add   <= 5'h0;
                        cnt            <= '0;
                        seen_busy      <= 1'b0;
                        state          <= S_CFG_ACK;
                    end
                end
                S_RST_ACK, S_POLL_ACK, S_CFG_ACK: begin
                    cnt <= cnt + 32'd1;
                    if (mdio.busy) seen_busy <= 1'b1;
                    if (state == S_POLL_ACK && mdio.rd_valid)
                        bit15 <= mdio.rd_data[15];
                    if (ack_fall) begin
                        if (state == S_RST_ACK) begin
                            state <= S_POLL_RD;
                        end else if (state == S_POLL_ACK) begin
                            if (!poll_hi) begin
                                state <= S_CFG_WR;
                            end else if (polls == PCW'(POLL_MAX)) begin
                                state   <= S_ERR;
                                error   <= 1'b1;
                                err_phy <= idx;
                            end else begin
                                state <= S_POLL_RD;
                            end
                        end else if (idx == IDX_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= S_RST_WR;
                        end
                    end else if (ack_to) begin
                        state   <= S_ERR;
                        error   <= 1'b1;
                        err_phy <= idx;
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        done    <= 1'b0;
                        error   <= 1'b0;
                        err_phy <= '0;
                        cnt     <= '0;
                        state   <= S_PWAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_cfg_sequencer.sv
// Scoreboard bench for mdio_cfg_sequencer with a randomized MDIO/PHY model.
// Expected request streams come from a per-PHY transaction-list model.
module tb_mdio_cfg_sequencer;
    localparam int          NUM_PHY  = 2;
    localparam int          PHY_BASE = 1;
    localparam int          PWR_WAIT = 8;
    localparam int          POLL_MAX = 16;
    localparam int          BUSY_TO  = 32;
    localparam logic [15:0] BMCR     = 16'h3100;

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 done, 3 error
        int          phy;
        logic [15:0] data;
        bit          tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       done;
    logic       error;
    logic [2:0] err_phy;

    mdio_cfg_if mdio();

    mdio_cfg_sequencer #(
        .NUM_PHY (NUM_PHY),
        .PHY_BASE(5'(PHY_BASE)),
        .PWR_WAIT(PWR_WAIT),
        .POLL_MAX(POLL_MAX),
        .BUSY_TO (BUSY_TO),
        .BMCR_CFG(BMCR)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mdio   (mdio),
        .done   (done),
        .error  (error),
        .err_phy(err_phy)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t q[$];
    int   clr[NUM_PHY];
    int   hang_phy = -1;
    int   start_cyc = 0;
    bit   first_pend = 0;
    int   last_req_cyc = 0;
    int   req_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Reference: clr[p] = number of reads answering bit15=1 before it clears.
    task automatic build(input int c0, input int c1, input int hang);
        int c[NUM_PHY];
        c[0] = c0;
        c[1] = c1;
        clr = c;
        hang_phy = hang;
        for (int p = 0; p < NUM_PHY; p++) begin
            int nrd;
            q.push_back('{0, p, 16'h8000, 1'b0});
            nrd = (c[p] >= POLL_MAX) ? POLL_MAX : c[p] + 1;
            for (int i = 0; i < nrd; i++) q.push_back('{1, p, 16'h0, 1'b0});
            if (c[p] >= POLL_MAX) begin
                q.push_back('{3, p, 16'h0, 1'b0});
                return;
            end
            q.push_back('{0, p, BMCR, 1'b0});
            if (hang == p) begin
                q.push_back('{3, p, 16'h0, 1'b1});
                return;
            end
        end
        q.push_back('{2, 0, 16'h0, 1'b0});
    endtask

    // MDIO master + PHY model.
    initial begin
        bit          s_act = 0;
        bit          s_rd = 0;
        bit          s_hang = 0;
        int          s_phy = 0;
        int          s_dly = 0;
        int          s_len = 0;
        int          rcnt[8];
        logic [15:0] tmp;
        mdio.busy = 1'b0;
        mdio.rd_valid = 1'b0;
        mdio.rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mdio.busy = 1'b0;
                mdio.rd_valid = 1'b0;
                s_act = 0;
            end else begin
                mdio.rd_valid = 1'b0;
                mdio.rd_data = 16'($urandom);
                if (s_act && s_hang && error) s_act = 0;
                if (!s_act) begin
                    if (mdio.wren || mdio.rden) begin
                        s_act = 1;
                        s_rd = mdio.rden;
                        s_phy = int'(mdio.phy_add_o) - PHY_BASE;
                        s_hang = mdio.wren && mdio.wr_data == BMCR
                                 && s_phy == hang_phy;
                        if (mdio.wren && mdio.wr_data == 16'h8000
                            && s_phy >= 0 && s_phy < NUM_PHY)
                            rcnt[s_phy] = 0;
                        s_dly = $urandom_range(1, 3);
                        s_len = $urandom_range(2, 5);
                    end
                end else if (!s_hang) begin
                    if (s_dly > 0) begin
                        s_dly--;
                        if (s_dly == 0) mdio.busy = 1'b1;
                    end else begin
                        s_len--;
                        if (s_len == 1 && s_rd) begin
                            tmp = 16'($urandom);
                            if (s_phy >= 0 && s_phy < NUM_PHY) begin
                                tmp[15] = rcnt[s_phy] < clr[s_phy];
                                rcnt[s_phy]++;
                            end
                            mdio.rd_data = tmp;
                            mdio.rd_valid = 1'b1;
                        end
                        if (s_len == 0) begin
                            mdio.busy = 1'b0;
                            s_act = 0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every request and on done/error rise.
    initial begin
        bit   prev_req = 0;
        bit   prev_done = 0;
        bit   prev_err = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mdio.wren || mdio.rden) begin
                req_count++;
                chk("req_excl", int'(mdio.wren & mdio.rden), 0);
                chk("req_1cyc", int'(prev_req), 0);
                chk("req_not_busy", int'(mdio.busy), 0);
                if (first_pend) begin
                    chk("pwr_wait", int'(cyc - start_cyc >= PWR_WAIT), 1);
                    first_pend = 0;
                end
                last_req_cyc = cyc;
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req: wren=%0b rden=%0b phy=%0d",
                             mdio.wren, mdio.rden, mdio.phy_add_o);
                end else begin
                    e = q.pop_front();
                    chk("req_kind", mdio.rden ? 1 : 0, e.kind);
                    chk("phy_add", int'(mdio.phy_add_o), PHY_BASE + e.phy);
                    chk("reg_add", int'(mdio.reg_add), 0);
                    if (mdio.wren) chk("wr_data", int'(mdio.wr_data), int'(e.data));
                end
            end
            prev_req = mdio.wren || mdio.rden;
            if ((done && !prev_done) || (error && !prev_err)) begin
                chk("done_err_excl", int'(done & error), 0);
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_end: done=%0b error=%0b", done, error);
                end else begin
                    e = q.pop_front();
                    chk("end_kind", error ? 3 : 2, e.kind);
                    chk("err_phy", int'(err_phy), error ? e.phy : 0);
                    if (e.tmo) chk("timeout_cyc", cyc - last_req_cyc, BUSY_TO);
                end
            end
            prev_done = done;
            prev_err = error;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        first_pend = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_end: no done/error after %0d cycles", name, n);
        end
        @(negedge clk);
        chk({name, "_drained"}, q.size(), 0);
    endtask

    initial begin
        int n;
        int rc0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wren", int'(mdio.wren), 0);
        chk("rst_rden", int'(mdio.rden), 0);
        chk("rst_phy", int'(mdio.phy_add_o), 0);
        chk("rst_wdata", int'(mdio.wr_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_errphy", int'(err_phy), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bit15 clears on 3rd poll; extra start while polling is ignored.
        build(2, 2, -1);
        pulse_start();
        n = 0;
        while (!mdio.rden && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("A_saw_read", int'(mdio.rden), 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("A");
        chk("A_done", int'(done), 1);
        chk("A_error", int'(error), 0);

        // Rerun from DONE, random poll counts.
        build($urandom_range(0, 4), $urandom_range(0, 4), -1);
        pulse_start();
        chk("B_done_clr", int'(done), 0);
        wait_end("B");
        chk("B_done", int'(done), 1);

        // PHY 2 never leaves reset.
        build(1, 99, -1);
        pulse_start();
        wait_end("C");
        chk("C_error", int'(error), 1);
        chk("C_done", int'(done), 0);
        chk("C_errphy", int'(err_phy), 1);

        // Busy never rises after PHY 2 config write.
        build(0, 0, 1);
        pulse_start();
        chk("D_err_clr", int'(error), 0);
        wait_end("D");
        chk("D_error", int'(error), 1);
        chk("D_errphy", int'(err_phy), 1);
        hang_phy = -1;

        for (int r = 0; r < 4; r++) begin
            int c0;
            int c1;
            c0 = $urandom_range(0, 5);
            c1 = ($urandom_range(0, 3) == 0) ? 20 : $urandom_range(0, 5);
            build(c0, c1, -1);
            pulse_start();
            wait_end("R");
            chk("R_outcome", int'(error), int'(c1 >= POLL_MAX));
        end

        // Asynchronous reset during the reset-write acknowledge.
        build(2, 2, -1);
        pulse_start();
        n = 0;
        while (!(mdio.wren && mdio.wr_data == 16'h8000) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("E_saw_wr", int'(mdio.wren), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("E_wren", int'(mdio.wren), 0);
        chk("E_rden", int'(mdio.rden), 0);
        chk("E_phy", int'(mdio.phy_add_o), 0);
        chk("E_wdata", int'(mdio.wr_data), 0);
        chk("E_done", int'(done), 0);
        chk("E_error", int'(error), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rc0 = req_count;
        repeat (40) @(negedge clk);
        chk("E_no_req", req_count - rc0, 0);
        chk("E_idle_done", int'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
